// File: rtl/datamem_arbiter_if.sv
// Bundle of the two requester ports and the shared single-port memory command
// bus that the arbiter sits between.
interface datamem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // Handshake: a requester raises req_x with we_x/addr_x/wdata_x/lock_x and
    // holds them stable until it samples gnt_x=1 on a rising clock edge; that
    // edge completes the command. A read returns on rvalid_x one cycle later.
    logic          req_a;
    logic          we_a;
    logic          lock_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
    logic          gnt_a;
    logic          rvalid_a;
    logic [DW-1:0] rdata_a;

    logic          req_b;
    logic          we_b;
    logic          lock_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic          gnt_b;
    logic          rvalid_b;
    logic [DW-1:0] rdata_b;

    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters plus the memory itself.
    modport master (
        output req_a, we_a, lock_a, addr_a, wdata_a,
        input  gnt_a, rvalid_a, rdata_a,
        output req_b, we_b, lock_b, addr_b, wdata_b,
        input  gnt_b, rvalid_b, rdata_b,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

    // The arbiter.
    modport slave (
        input  req_a, we_a, lock_a, addr_a, wdata_a,
        output gnt_a, rvalid_a, rdata_a,
        input  req_b, we_b, lock_b, addr_b, wdata_b,
        output gnt_b, rvalid_b, rdata_b,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter for a single-port data memory, with optional
// locked bursts of up to BURST_MAX consecutive grants to one owner.
module datamem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    datamem_arbiter_if.slave     bus,
    output logic [1:0]           o_dbg_state,
    output logic                 o_dbg_ptr,
    output logic [3:0]           o_dbg_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX = 4'(BURST_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_ptr;        // 0 favours A, 1 favours B
    logic       w_ptr_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_cnt_inc;
    logic       r_rvalid_a;
    logic       r_rvalid_b;
    logic       w_gnt_a;
    logic       w_gnt_b;

    assign w_cnt_inc = r_cnt + 4'd1;

    // Grant decode; reset overrides so nothing reaches the memory during rst.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    w_gnt_a = ~r_ptr;
                    w_gnt_b = r_ptr;
                end else begin
                    w_gnt_a = bus.req_a;
                    w_gnt_b = bus.req_b;
                end
            end
            ST_LOCK_A: w_gnt_a = bus.req_a;
            ST_LOCK_B: w_gnt_b = bus.req_b;
            default: ;
        endcase
        if (rst) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        if (w_gnt_a) begin
            w_ptr_nxt = 1'b1;
        end else if (w_gnt_b) begin
            w_ptr_nxt = 1'b0;
        end
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (w_gnt_a && bus.lock_a) begin
                    w_state_nxt = ST_LOCK_A;
                    w_cnt_nxt   = 4'd1;
                end else if (w_gnt_b && bus.lock_b) begin
                    w_state_nxt = ST_LOCK_B;
                    w_cnt_nxt   = 4'd1;
                end
            end
            ST_LOCK_A: begin
                // Owner dropped out, released the lock, or used up its burst.
                if (!w_gnt_a || !bus.lock_a || (w_cnt_inc == LP_MAX)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_LOCK_B: begin
                if (!w_gnt_b || !bus.lock_b || (w_cnt_inc == LP_MAX)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_cnt      <= 4'd0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rvalid_a <= w_gnt_a & ~bus.we_a;
            r_rvalid_b <= w_gnt_b & ~bus.we_b;
        end
    end

    assign bus.gnt_a     = w_gnt_a;
    assign bus.gnt_b     = w_gnt_b;
    assign bus.mem_read  = (w_gnt_a & ~bus.we_a) | (w_gnt_b & ~bus.we_b);
    assign bus.mem_write = (w_gnt_a & bus.we_a) | (w_gnt_b & bus.we_b);
    assign bus.mem_addr  = w_gnt_b ? bus.addr_b : bus.addr_a;
    assign bus.mem_wdata = w_gnt_b ? bus.wdata_b : bus.wdata_a;
    assign bus.rvalid_a  = r_rvalid_a;
    assign bus.rvalid_b  = r_rvalid_b;
    assign bus.rdata_a   = bus.mem_rdata;
    assign bus.rdata_b   = bus.mem_rdata;

    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;
    assign o_dbg_cnt   = r_cnt;

    a_one_hot_gnt: assert property (@(posedge clk) disable iff (rst) !(w_gnt_a && w_gnt_b));
    a_one_hot_rvalid: assert property (@(posedge clk) disable iff (rst) !(r_rvalid_a && r_rvalid_b));

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: a scoreboard of expected grants and read
// returns, each stamped with the cycle it must appear in.
module tb_datamem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int GW = 34;  // {cyc[15:0], port, we, addr, wdata}
    localparam int RW = 25;  // {cyc[15:0], port, data}

    logic clk;
    logic rst;
    logic preload;
    logic [15:0] cyc;
    logic [1:0]  dbg_state;
    logic        dbg_ptr;
    logic [3:0]  dbg_cnt;
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] mem_rdata_r;

    logic [GW-1:0] exp_g_q[$];
    logic [RW-1:0] exp_r_q[$];

    int total;
    int bad;

    datamem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    datamem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr),
        .o_dbg_cnt   (dbg_cnt)
    );

    // Clock and cycle stamp.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 16'd0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    // Registered single-port memory.
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 8'h5A;
        end else begin
            if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.mem_read) mem_rdata_r <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rdata_r;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wd);
        bus.req_a = req; bus.we_a = we; bus.lock_a = lock; bus.addr_a = addr; bus.wdata_a = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [7:0] addr, input logic [7:0] wd);
        bus.req_b = req; bus.we_b = we; bus.lock_b = lock; bus.addr_b = addr; bus.wdata_b = wd;
    endtask

    task automatic exp_gnt(input logic [15:0] c, input logic port, input logic we,
                           input logic [7:0] addr, input logic [7:0] wd);
        exp_g_q.push_back({c, port, we, addr, wd});
    endtask

    task automatic exp_rd(input logic [15:0] c, input logic port, input logic [7:0] data);
        exp_r_q.push_back({c, port, data});
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a grant or a read return.
    task automatic monitor();
        logic [GW-1:0] eg;
        logic [GW-1:0] ag;
        logic [RW-1:0] er;
        logic [RW-1:0] ar;
        forever begin
            @(negedge clk);
            total++;
            if (bus.gnt_a || bus.gnt_b) begin
                ag = {cyc, bus.gnt_b, bus.mem_write, bus.mem_addr, bus.mem_wdata};
                if (exp_g_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_unexpected actual=0x%0h expected=none", ag);
                end else begin
                    eg = exp_g_q.pop_front();
                    if (ag !== eg || (bus.gnt_a && bus.gnt_b) || (bus.mem_read == bus.mem_write)) begin
                        bad++;
                        $display("FAIL grant actual=0x%0h expected=0x%0h gnt_a=%0b gnt_b=%0b rd=%0b wr=%0b",
                                 ag, eg, bus.gnt_a, bus.gnt_b, bus.mem_read, bus.mem_write);
                    end
                end
            end else if (bus.mem_read || bus.mem_write) begin
                bad++;
                $display("FAIL mem_cmd_no_grant actual rd=%0b wr=%0b expected rd=0 wr=0 cyc=%0d",
                         bus.mem_read, bus.mem_write, cyc);
            end
            if (bus.rvalid_a || bus.rvalid_b) begin
                total++;
                ar = {cyc, bus.rvalid_b, (bus.rvalid_b ? bus.rdata_b : bus.rdata_a)};
                if (exp_r_q.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected actual=0x%0h expected=none", ar);
                end else begin
                    er = exp_r_q.pop_front();
                    if (ar !== er || (bus.rvalid_a && bus.rvalid_b)) begin
                        bad++;
                        $display("FAIL read_return actual=0x%0h expected=0x%0h rva=%0b rvb=%0b",
                                 ar, er, bus.rvalid_a, bus.rvalid_b);
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        preload = 1'b1;
        set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        fork
            monitor();
        join_none
        step();
        step();

        // Reset state, with A requesting to prove grants are held off.
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ptr", 32'(dbg_ptr), 32'd0);
        check("rst_cnt", 32'(dbg_cnt), 32'd0);
        check("rst_gnt", {30'd0, bus.gnt_a, bus.gnt_b}, 32'd0);
        check("rst_mem_cmd", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_rvalid", {30'd0, bus.rvalid_a, bus.rvalid_b}, 32'd0);
        preload = 1'b0;
        rst = 1'b0;

        // Lone read of 0x10 -> 0x5A one cycle later on port A only.
        exp_gnt(cyc, 1'b0, 1'b0, 8'h10, 8'h00);
        exp_rd(cyc + 16'd1, 1'b0, 8'h5A);
        step();
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // Contention from reset: both write, alternating A,B,A,B.
        apply_reset();
        set_a(1'b1, 1'b1, 1'b0, 8'h20, 8'h11);
        set_b(1'b1, 1'b1, 1'b0, 8'h30, 8'h22);
        exp_gnt(cyc,         1'b0, 1'b1, 8'h20, 8'h11);
        exp_gnt(cyc + 16'd1, 1'b1, 1'b1, 8'h30, 8'h22);
        exp_gnt(cyc + 16'd2, 1'b0, 1'b1, 8'h20, 8'h11);
        exp_gnt(cyc + 16'd3, 1'b1, 1'b1, 8'h30, 8'h22);
        repeat (4) step();
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Locked burst of 4 reads on A while B waits, then B.
        set_a(1'b1, 1'b0, 1'b1, 8'h30, 8'h00);
        set_b(1'b1, 1'b1, 1'b0, 8'h40, 8'h33);
        for (int i = 0; i < 4; i++) begin
            exp_gnt(cyc + 16'(i), 1'b0, 1'b0, 8'h30, 8'h00);
            exp_rd(cyc + 16'(i + 1), 1'b0, 8'h22);
        end
        exp_gnt(cyc + 16'd4, 1'b1, 1'b1, 8'h40, 8'h33);
        step();
        check("burst_state_lock_a", 32'(dbg_state), 32'd1);
        check("burst_cnt_first", 32'(dbg_cnt), 32'd1);
        repeat (3) step();
        check("burst_max_exit_state", 32'(dbg_state), 32'd0);
        check("burst_max_exit_cnt", 32'(dbg_cnt), 32'd0);
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Early unlock: lock for two grants, third grant unlocked, then B reads.
        set_a(1'b1, 1'b1, 1'b1, 8'h50, 8'h44);
        set_b(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        exp_gnt(cyc,         1'b0, 1'b1, 8'h50, 8'h44);
        exp_gnt(cyc + 16'd1, 1'b0, 1'b1, 8'h50, 8'h44);
        exp_gnt(cyc + 16'd2, 1'b0, 1'b1, 8'h50, 8'h44);
        exp_gnt(cyc + 16'd3, 1'b1, 1'b0, 8'h20, 8'h00);
        exp_rd(cyc + 16'd4, 1'b1, 8'h11);
        step();
        step();
        bus.lock_a = 1'b0;
        step();
        check("unlock_state_idle", 32'(dbg_state), 32'd0);
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Lock drop: B locked, B stops requesting, one idle cycle, then A.
        set_b(1'b1, 1'b0, 1'b1, 8'h50, 8'h00);
        exp_gnt(cyc, 1'b1, 1'b0, 8'h50, 8'h00);
        exp_rd(cyc + 16'd1, 1'b1, 8'h44);
        exp_gnt(cyc + 16'd2, 1'b0, 1'b0, 8'h10, 8'h00);
        exp_rd(cyc + 16'd3, 1'b0, 8'h5A);
        step();
        check("drop_state_lock_b", 32'(dbg_state), 32'd2);
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_a(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        step();
        step();
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset mid-read: the locked read's return must never appear.
        set_a(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
        exp_gnt(cyc, 1'b0, 1'b0, 8'h10, 8'h00);
        step();
        rst = 1'b1;
        #1;
        check("midrst_rvalid_a", 32'(bus.rvalid_a), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        rst = 1'b0;
        check("postrst_state", 32'(dbg_state), 32'd0);
        check("postrst_ptr", 32'(dbg_ptr), 32'd0);
        check("postrst_cnt", 32'(dbg_cnt), 32'd0);

        // First edge after reset arbitrates normally, pointer favouring A.
        set_a(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        set_b(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
        exp_gnt(cyc,         1'b0, 1'b0, 8'h20, 8'h00);
        exp_gnt(cyc + 16'd1, 1'b1, 1'b0, 8'h30, 8'h00);
        exp_rd(cyc + 16'd1, 1'b0, 8'h11);
        exp_rd(cyc + 16'd2, 1'b1, 8'h22);
        step();
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // B locked writes hit BURST_MAX while A waits; A wins right after.
        set_b(1'b1, 1'b1, 1'b1, 8'h60, 8'h55);
        for (int i = 0; i < 4; i++) begin
            exp_gnt(cyc + 16'(i), 1'b1, 1'b1, 8'h60, 8'h55);
        end
        exp_gnt(cyc + 16'd4, 1'b0, 1'b1, 8'h61, 8'h66);
        step();
        set_a(1'b1, 1'b1, 1'b0, 8'h61, 8'h66);
        repeat (3) step();
        check("b_burst_exit_state", 32'(dbg_state), 32'd0);
        check("b_burst_exit_ptr", 32'(dbg_ptr), 32'd0);
        step();
        set_a(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        repeat (3) step();
        check("grant_queue_drained", 32'(exp_g_q.size()), 32'd0);
        check("read_queue_drained", 32'(exp_r_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning the memory address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning the data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, range 2..15, meaning the maximum consecutive grants one locked owner receives.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_a, we_a, lock_a  input  1 each  port A request, write-enable (1=write, 0=read), and burst lock.
REQ-007 addr_a  input  AW, wdata_a  input  DW  port A address and write data.
REQ-008 gnt_a  output  1, rvalid_a  output  1, rdata_a  output  DW  port A grant, read-valid and read data.
REQ-009 req_b, we_b, lock_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  SHALL mirror the port A signals for port B.
REQ-010 mem_read  output  1, mem_write  output  1, mem_addr  output  AW, mem_wdata  output  DW  are the memory command outputs.
REQ-011 mem_rdata  input  DW  is the memory read data, registered inside the memory, valid the cycle after mem_read is sampled.

Function
REQ-012 Handshake: a requester SHALL hold req/we/addr/wdata/lock stable until it samples gnt=1 at a rising edge; that edge completes the command.
REQ-013 gnt_a/gnt_b SHALL be combinational from the current state and requests, one-hot or zero, never both 1.
REQ-014 mem_read SHALL equal (gnt_a & ~we_a) | (gnt_b & ~we_b), and mem_write SHALL equal (gnt_a & we_a) | (gnt_b & we_b).
REQ-015 mem_addr/mem_wdata SHALL carry the granted port's addr/wdata, and port A's values when there is no grant.
REQ-016 rvalid_x SHALL be a register set for exactly one cycle following a read grant to port x, with zero write-to-read turnaround and no bubbles.
REQ-017 rdata_a and rdata_b SHALL both equal mem_rdata, meaningful only while the matching rvalid is 1.
REQ-018 FSM states SHALL be IDLE, LOCK_A and LOCK_B.
REQ-019 In IDLE, a lone requester SHALL be granted the same cycle.
REQ-020 In IDLE, when both ports request, the round-robin pointer SHALL pick the winner; the pointer resets to favour A.
REQ-021 After any grant to port x, the pointer SHALL favour the other port.
REQ-022 IDLE -> LOCK_x SHALL occur on a grant to x with lock_x=1; the burst counter then loads 1.
REQ-023 In LOCK_x, only x SHALL be granted; the other port SHALL get gnt=0 even if requesting.
REQ-024 In LOCK_x, a grant with lock_x=1 SHALL increment the counter, and on reaching BURST_MAX the FSM SHALL go to IDLE.
REQ-025 In LOCK_x, a grant with lock_x=0 SHALL go to IDLE; that grant is the last of the burst.
REQ-026 In LOCK_x with req_x=0, no grant SHALL be issued and the FSM SHALL go to IDLE next cycle.
REQ-027 The counter SHALL clear on every entry to IDLE.
REQ-028 The forced exit at BURST_MAX SHALL leave the pointer favouring the other port, so a waiting requester wins the next cycle.
REQ-029 Back-to-back grants to the same port in IDLE SHALL be allowed only when the other port is not requesting.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE, the pointer SHALL favour A, the burst counter SHALL be 0, and rvalid_a/rvalid_b SHALL be 0, all asynchronously.
REQ-031 While rst=1, gnt_a, gnt_b, mem_read and mem_write SHALL be forced to 0.
REQ-032 A reset asserted mid-burst SHALL abandon the lock and suppress any pending rvalid; no read return is delivered after reset.
REQ-033 The first rising edge after rst deasserts SHALL arbitrate normally.

Verification
REQ-034 Lone read: req_a=1, we_a=0, addr_a=0x10, memory[0x10]=0x5A -> gnt_a=1 in cycle N; rvalid_a=1 with rdata_a=0x5A in N+1; rvalid_b=0.
REQ-035 Contention from reset: req_a and req_b both held as writes -> grants A, B, A, B on consecutive cycles; mem_write=1 every cycle.
REQ-036 Locked burst: lock_a=1 and req_a held with BURST_MAX=4 while req_b=1 -> gnt_a for 4 cycles, then gnt_b in cycle 5.
REQ-037 Early unlock: lock_a=1 for 2 grants, then lock_a=0 on the 3rd -> 3 A grants, FSM IDLE, then B granted.
REQ-038 Lock drop: in LOCK_B, req_b falls while req_a=1 -> one cycle with no grant, then gnt_a.
REQ-039 Reset mid-read: rst pulsed in the cycle after a read grant -> rvalid is 0 immediately, and the FSM is IDLE with the pointer favouring A after release.
